// File: rtl/instr_pager.sv
// instr_pager
//   Paged instruction store sitting between a small core and its program
//   memory. The core sees one page of 2^PC_LEN words at a time; it can ask for
//   a different page and the switch takes effect when its PC wraps to 0. A
//   loader can rewrite any page through a valid/ready word stream.
//
//   Optional build macro: INSTR_PARITY_EN adds one even-parity bit per stored
//   word and the PERR output.
//
// Ports
//   CLK        clock; every state change happens on its rising edge
//   RST        synchronous reset, active high
//   PC         core fetch address within the active page
//   INSTR      registered instruction word; zero while BUSY
//   PG_REQ     page-switch request strobe
//   PG_NUM     requested page, sampled with PG_REQ
//   PAGE       currently active page
//   LD_START   begin loading page LD_PAGE; ignored unless idle
//   LD_PAGE    target page, sampled with LD_START
//   LD_VALID   loader has a word on LD_DATA
//   LD_READY   pager accepts a word this cycle (high only while loading)
//   LD_DATA    load word
//   LD_DONE    one-cycle pulse after the final word of a page is written
//   BUSY       a load is in progress on the active page
//   PERR       (INSTR_PARITY_EN only) registered parity error for INSTR
//   DBG_STATE  loader FSM state: 0 idle, 1 loading
module instr_pager #(
  parameter int PC_LEN    = 7,
  parameter int INSTR_LEN = 12,
  parameter int PAGE_BITS = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [PC_LEN-1:0]    PC,
  output logic [INSTR_LEN-1:0] INSTR,
  input  logic                 PG_REQ,
  input  logic [PAGE_BITS-1:0] PG_NUM,
  output logic [PAGE_BITS-1:0] PAGE,
  input  logic                 LD_START,
  input  logic [PAGE_BITS-1:0] LD_PAGE,
  input  logic                 LD_VALID,
  output logic                 LD_READY,
  input  logic [INSTR_LEN-1:0] LD_DATA,
  output logic                 LD_DONE,
  output logic                 BUSY,
`ifdef INSTR_PARITY_EN
  output logic                 PERR,
`endif
  output logic                 DBG_STATE
);

  localparam int ADDR_W = PAGE_BITS + PC_LEN;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [PC_LEN-1:0] LAST_WORD = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t               state;
  logic [PC_LEN-1:0]    cnt;
  logic [PAGE_BITS-1:0] ld_page_q;
  logic [PAGE_BITS-1:0] page_q;
  logic [PAGE_BITS-1:0] pend_page;
  logic                 pend_valid;

  // Storage has no reset: a reset must leave previously loaded code intact.
  logic [INSTR_LEN-1:0] mem [DEPTH];
`ifdef INSTR_PARITY_EN
  logic                 par [DEPTH];
`endif

  logic                 wr_en;
  logic                 last_wr;
  logic [PAGE_BITS-1:0] page_n;
  logic                 load_active_n;
  logic [PAGE_BITS-1:0] ld_page_n;
  logic                 busy_n;
  logic [ADDR_W-1:0]    rd_addr;
  logic [ADDR_W-1:0]    wr_addr;

  // Load handshake: a word transfers on a rising edge where LD_VALID and
  // LD_READY are both high. LD_READY is high for the whole load and does not
  // depend on LD_VALID; the loader may drop LD_VALID for any number of cycles
  // and the word counter simply waits.
  assign wr_en   = (state == ST_LOAD) && LD_VALID && LD_READY;
  assign last_wr = wr_en && (cnt == LAST_WORD);
  assign wr_addr = {ld_page_q, cnt};

  // Page that will be active after this edge. A request coinciding with
  // PC == 0 wins over an older pending request.
  always_comb begin
    page_n = page_q;
    if (PC == '0) begin
      if (PG_REQ) begin
        page_n = PG_NUM;
      end else if (pend_valid) begin
        page_n = pend_page;
      end
    end
  end

  // The fetch on this edge already uses the new page, and INSTR must read as
  // zero whenever BUSY will be high after the edge, so the blanking decision
  // is made from next-cycle load state and next-cycle page.
  assign load_active_n = (state == ST_IDLE) ? LD_START : !last_wr;
  assign ld_page_n     = (state == ST_IDLE) ? LD_PAGE : ld_page_q;
  assign busy_n        = load_active_n && (ld_page_n == page_n);
  assign rd_addr       = {page_n, PC};

  assign BUSY      = (state == ST_LOAD) && (ld_page_q == page_q);
  assign PAGE      = page_q;
  assign DBG_STATE = (state == ST_LOAD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ld_page_q  <= '0;
      page_q     <= '0;
      pend_page  <= '0;
      pend_valid <= 1'b0;
      INSTR      <= '0;
      LD_READY   <= 1'b0;
      LD_DONE    <= 1'b0;
`ifdef INSTR_PARITY_EN
      PERR       <= 1'b0;
`endif
    end else begin
      page_q <= page_n;
      if (PC == '0) begin
        pend_valid <= 1'b0;
      end else if (PG_REQ) begin
        pend_valid <= 1'b1;
        pend_page  <= PG_NUM;
      end

      INSTR <= busy_n ? '0 : mem[rd_addr];
`ifdef INSTR_PARITY_EN
      PERR  <= busy_n ? 1'b0 : ((^mem[rd_addr]) != par[rd_addr]);
`endif

      LD_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (LD_START) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            ld_page_q <= LD_PAGE;
            LD_READY  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            if (cnt == LAST_WORD) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              LD_READY <= 1'b0;
              LD_DONE  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          LD_READY <= 1'b0;
        end
      endcase
    end
  end

  // Writes are suppressed during reset so an aborted load stops exactly at
  // the last word accepted before RST.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      mem[wr_addr] <= LD_DATA;
`ifdef INSTR_PARITY_EN
      par[wr_addr] <= ^LD_DATA;
`endif
    end
  end

endmodule

// File: tb/tb_instr_pager.sv
module tb_instr_pager;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  PC;
  logic [11:0] INSTR;
  logic        PG_REQ;
  logic [2:0]  PG_NUM;
  logic [2:0]  PAGE;
  logic        LD_START;
  logic [2:0]  LD_PAGE;
  logic        LD_VALID;
  logic        LD_READY;
  logic [11:0] LD_DATA;
  logic        LD_DONE;
  logic        BUSY;
  logic        DBG_STATE;
`ifdef INSTR_PARITY_EN
  logic        PERR;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_pager dut (
    .CLK(CLK), .RST(RST), .PC(PC), .INSTR(INSTR),
    .PG_REQ(PG_REQ), .PG_NUM(PG_NUM), .PAGE(PAGE),
    .LD_START(LD_START), .LD_PAGE(LD_PAGE), .LD_VALID(LD_VALID),
    .LD_READY(LD_READY), .LD_DATA(LD_DATA), .LD_DONE(LD_DONE),
    .BUSY(BUSY),
`ifdef INSTR_PARITY_EN
    .PERR(PERR),
`endif
    .DBG_STATE(DBG_STATE)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1 ns after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Load page p with value (address ^ xv). gaps inserts an LD_VALID-low
  // cycle (with a stray LD_START) before every word.
  task automatic load_page(input int p, input logic [11:0] xv, input bit exp_busy, input bit gaps);
    LD_START = 1'b1;
    LD_PAGE  = 3'(p);
    step();
    LD_START = 1'b0;
    check("ld_ready_start", LD_READY, 1);
    check("busy_start", BUSY, exp_busy);
    for (int w = 0; w < 128; w++) begin
      if (gaps) begin
        LD_VALID = 1'b0;
        LD_START = 1'b1;
        LD_PAGE  = 3'(p + 3);
        step();
        LD_START = 1'b0;
        check("ld_ready_gap", LD_READY, 1);
        check("ld_done_gap", LD_DONE, 0);
        check("busy_gap", BUSY, exp_busy);
        if (exp_busy) check("instr_gap", INSTR, 0);
      end
      LD_VALID = 1'b1;
      LD_DATA  = 12'((p * 128 + w) ^ int'(xv));
      step();
      LD_VALID = 1'b0;
      if (w < 127) begin
        check("ld_done_mid", LD_DONE, 0);
        check("busy_mid", BUSY, exp_busy);
        if (exp_busy) check("instr_busy", INSTR, 0);
      end else begin
        check("ld_done_pulse", LD_DONE, 1);
        check("busy_end", BUSY, 0);
        check("ld_ready_end", LD_READY, 0);
        check("state_end", DBG_STATE, 0);
      end
    end
    step();
    check("ld_done_single", LD_DONE, 0);
  endtask

  // Sweep PC 0..127 on page p; words below new_upto hold address ^ xv.
  task automatic sweep(input int p, input logic [11:0] xv, input int new_upto);
    int e;
    for (int w = 0; w < 128; w++) begin
      PC = 7'(w);
      step();
      e = p * 128 + w;
      if (w < new_upto) e = e ^ int'(xv);
      check("sweep_page", PAGE, p);
      check("sweep_instr", INSTR, e);
    end
  endtask

  initial begin
    RST = 1'b1; PC = '0; PG_REQ = 1'b0; PG_NUM = '0;
    LD_START = 1'b0; LD_PAGE = '0; LD_VALID = 1'b0; LD_DATA = '0;
    step();
    step();
    check("rst_instr", INSTR, 0);
    check("rst_page", PAGE, 0);
    check("rst_ld_ready", LD_READY, 0);
    check("rst_ld_done", LD_DONE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_state", DBG_STATE, 0);
`ifdef INSTR_PARITY_EN
    check("rst_perr", PERR, 0);
`endif
    RST = 1'b0;
    PC  = 7'd1;

    // fill other pages with value = address while page 0 stays active
    for (int p = 1; p < 6; p++) load_page(p, 12'h000, 1'b0, 1'b0);
    // load active page 0 with stalls: BUSY, zero INSTR, LD_START ignored
    load_page(0, 12'h000, 1'b1, 1'b1);
    sweep(0, 12'h000, 0);

    // pending request to page 2 applied on PC wrap
    PC = 7'd5; PG_REQ = 1'b1; PG_NUM = 3'd2;
    step();
    PG_REQ = 1'b0;
    check("pend_page_hold", PAGE, 0);
    check("pend_instr5", INSTR, 5);
    for (int w = 6; w < 128; w++) begin
      PC = 7'(w);
      step();
      check("pend_wait_page", PAGE, 0);
      check("pend_wait_instr", INSTR, w);
    end
    PC = 7'd0;
    step();
    check("wrap_page", PAGE, 2);
    check("wrap_instr", INSTR, 256);
    PC = 7'd1;
    step();
    check("wrap_instr1", INSTR, 257);

    // later request overwrites pending
    PC = 7'd10; PG_REQ = 1'b1; PG_NUM = 3'd3;
    step();
    check("ovr_instr10", INSTR, 266);
    PC = 7'd11; PG_NUM = 3'd5;
    step();
    PG_REQ = 1'b0;
    PC = 7'd12;
    step();
    check("ovr_page_hold", PAGE, 2);
    check("ovr_instr12", INSTR, 268);
    PC = 7'd0;
    step();
    check("ovr_page", PAGE, 5);
    check("ovr_instr0", INSTR, 640);
    PC = 7'd7;
    step();
    check("ovr_instr7", INSTR, 647);
    // request at PC == 0 applies on the same edge
    PC = 7'd0; PG_REQ = 1'b1; PG_NUM = 3'd4;
    step();
    PG_REQ = 1'b0;
    check("imm_page", PAGE, 4);
    check("imm_instr", INSTR, 512);
    PC = 7'd3;
    step();
    PC = 7'd0;
    step();
    check("imm_cleared_page", PAGE, 4);
    check("imm_cleared_instr", INSTR, 512);
    PG_REQ = 1'b1; PG_NUM = 3'd0;
    step();
    PG_REQ = 1'b0;
    check("back0_page", PAGE, 0);
    PC = 7'd1;
    step();
    check("back0_instr", INSTR, 1);

    // switch into a page while it is being loaded
    LD_START = 1'b1; LD_PAGE = 3'd3;
    step();
    LD_START = 1'b0;
    check("into_busy_before", BUSY, 0);
    check("into_instr_before", INSTR, 1);
    PC = 7'd0; PG_REQ = 1'b1; PG_NUM = 3'd3;
    step();
    PG_REQ = 1'b0;
    check("into_page", PAGE, 3);
    check("into_busy", BUSY, 1);
    check("into_instr", INSTR, 0);
    for (int w = 0; w < 128; w++) begin
      LD_VALID = 1'b1; LD_DATA = 12'(384 + w);
      step();
    end
    LD_VALID = 1'b0;
    check("into_done", LD_DONE, 1);
    check("into_busy_end", BUSY, 0);
    check("into_instr_end", INSTR, 384);
    PG_REQ = 1'b1; PG_NUM = 3'd0;
    step();
    PG_REQ = 1'b0;
    check("into_back0", PAGE, 0);
    PC = 7'd1;

    // load aborted by reset at word 40; pending request is discarded
    LD_START = 1'b1; LD_PAGE = 3'd0;
    step();
    LD_START = 1'b0;
    for (int w = 0; w < 40; w++) begin
      LD_VALID = 1'b1; LD_DATA = 12'(w) ^ 12'hF00;
      step();
    end
    LD_VALID = 1'b0; PG_REQ = 1'b1; PG_NUM = 3'd3;
    step();
    PG_REQ = 1'b0;
    check("abort_busy_pre", BUSY, 1);
    LD_VALID = 1'b1; LD_DATA = 12'd40 ^ 12'hF00; RST = 1'b1;
    step();
    RST = 1'b0; LD_VALID = 1'b0;
    check("abort_state", DBG_STATE, 0);
    check("abort_ld_ready", LD_READY, 0);
    check("abort_page", PAGE, 0);
    check("abort_instr", INSTR, 0);
    check("abort_busy", BUSY, 0);
    check("abort_ld_done", LD_DONE, 0);
    sweep(0, 12'hF00, 40);

`ifdef INSTR_PARITY_EN
    PC = 7'd0; PG_REQ = 1'b1; PG_NUM = 3'd1;
    step();
    PG_REQ = 1'b0;
    dut.mem[137] = dut.mem[137] ^ 12'h001;
    PC = 7'd8;
    step();
    check("par_instr8", INSTR, 136);
    check("par_perr8", PERR, 0);
    PC = 7'd9;
    step();
    check("par_instr9", INSTR, 136);
    check("par_perr9", PERR, 1);
    PC = 7'd10;
    step();
    check("par_instr10", INSTR, 138);
    check("par_perr10", PERR, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
